// File: rtl/zx_cpu_sched.sv
// zx_cpu_sched: T-state clock-enable scheduler, ULA-style memory contention
// and frame interrupt for the 48K Z80 core.
// Optional build macro ZX_CONTEND_IO_EN: also contend I/O cycles (iorq=0 with
// a[0]=0 or a[15:14]=2'b01). Without it only mreq accesses are contended.
module zx_cpu_sched #(
    parameter int unsigned DIV        = 8,
    parameter int unsigned LINE_T     = 224,
    parameter int unsigned LINES      = 312,
    parameter int unsigned DISP_LINE  = 64,
    parameter int unsigned CONT_START = 0,
    parameter int unsigned INT_START  = 0,
    parameter int unsigned INT_LEN    = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] a,
    input  logic        mreq,
    input  logic        iorq,
    output logic        cep,
    output logic        cen,
    output logic        mi,
    output logic [7:0]  hcount,
    output logic [8:0]  vcount,
    output logic        stall
);

    localparam int unsigned PH_W       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned H_W        = 8;
    localparam int unsigned V_W        = 9;
    localparam int unsigned F_W        = 17;
    localparam int unsigned D_W        = 3;
    localparam int unsigned DISP_LINES = 192;
    localparam int unsigned CONT_LEN   = 128;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [H_W-1:0]   hcount_q, hcount_d;
    logic [V_W-1:0]   vcount_q, vcount_d;
    logic [D_W-1:0]   delay_q, delay_d;
    logic             held_q, held_d;
    logic             cep_q, cep_d;
    logic             cen_q, cen_d;
    logic             mi_q, mi_d;
    logic             stall_q, stall_d;

    logic [V_W-1:0]   voff_c;
    logic [H_W-1:0]   hoff_c;
    logic [F_W-1:0]   frame_c;
    logic [F_W-1:0]   int_off_c;
    logic             mem_hit_c;
    logic             io_hit_c;
    logic             contend_c;
    logic             in_int_c;
    logic [D_W-1:0]   delay_tab_c;

    // Free-running phase / T-state / line counters; never held by contention
    always_comb begin
        phase_d  = phase_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (phase_q == PH_W'(DIV - 1)) begin
            phase_d = '0;
            if (hcount_q == H_W'(LINE_T - 1)) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_W'(LINES - 1)) ? '0 : vcount_q + V_W'(1);
            end else begin
                hcount_d = hcount_q + H_W'(1);
            end
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
    end

    // Contention predicate, delay table lookup and interrupt window test
    always_comb begin
        voff_c    = vcount_q - V_W'(DISP_LINE);
        hoff_c    = hcount_q - H_W'(CONT_START);
        mem_hit_c = !mreq && (a[15:14] == 2'b01);
`ifdef ZX_CONTEND_IO_EN
        io_hit_c  = !iorq && (!a[0] || (a[15:14] == 2'b01));
`else
        io_hit_c  = 1'b0;
`endif
        // Offsets wrap below the window start, so one compare bounds both ends
        contend_c = (mem_hit_c || io_hit_c) && (voff_c < V_W'(DISP_LINES)) &&
                    (hoff_c < H_W'(CONT_LEN)) && !held_q;
        case (hoff_c[2:0])
            3'd0:    delay_tab_c = D_W'(6);
            3'd1:    delay_tab_c = D_W'(5);
            3'd2:    delay_tab_c = D_W'(4);
            3'd3:    delay_tab_c = D_W'(3);
            3'd4:    delay_tab_c = D_W'(2);
            3'd5:    delay_tab_c = D_W'(1);
            default: delay_tab_c = D_W'(0);
        endcase
        frame_c   = F_W'(vcount_q) * F_W'(LINE_T) + F_W'(hcount_q);
        int_off_c = frame_c - F_W'(INT_START);
        in_int_c  = int_off_c < F_W'(INT_LEN);
    end

    // RUN/STALL next state, enable pulses, held flag and interrupt level
    always_comb begin
        state_d = state_q;
        delay_d = delay_q;
        held_d  = held_q;
        stall_d = stall_q;
        mi_d    = mi_q;
        cep_d   = 1'b0;
        cen_d   = 1'b0;
        if (phase_q == '0) begin
            mi_d = !in_int_c;
            case (state_q)
                ST_RUN: begin
                    if (mreq && iorq) begin
                        held_d = 1'b0;
                    end
                    if (contend_c && (delay_tab_c != '0)) begin
                        delay_d = delay_tab_c;
                        stall_d = 1'b1;
                        state_d = ST_STALL;
                    end else begin
                        if (contend_c) begin
                            held_d = 1'b1;
                        end
                        cep_d = 1'b1;
                    end
                end
                ST_STALL: begin
                    if (delay_q <= D_W'(1)) begin
                        delay_d = '0;
                        stall_d = 1'b0;
                        held_d  = 1'b1;
                        cep_d   = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        delay_d = delay_q - D_W'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
        if (phase_q == PH_W'(DIV / 2)) begin
            cen_d = !stall_q;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            phase_q  <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            delay_q  <= '0;
            held_q   <= 1'b0;
            cep_q    <= 1'b0;
            cen_q    <= 1'b0;
            mi_q     <= 1'b1;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            delay_q  <= delay_d;
            held_q   <= held_d;
            cep_q    <= cep_d;
            cen_q    <= cen_d;
            mi_q     <= mi_d;
            stall_q  <= stall_d;
        end
    end

    assign cep    = cep_q;
    assign cen    = cen_q;
    assign mi     = mi_q;
    assign stall  = stall_q;
    assign hcount = hcount_q;
    assign vcount = vcount_q;

endmodule

// File: tb/tb_zx_cpu_sched.sv
// Directed bench for zx_cpu_sched. The contended line window is moved to
// DISP_LINE=4 so every scenario is reached within the first few lines.
module tb_zx_cpu_sched;

    logic        clock;
    logic        reset;
    logic [15:0] a;
    logic        mreq;
    logic        iorq;
    logic        cep;
    logic        cen;
    logic        mi;
    logic [7:0]  hcount;
    logic [8:0]  vcount;
    logic        stall;

    int n_checks;
    int n_fails;
    int n;        // index of the last clock edge since reset release
    int exp_io;

    // First contended edge: line 4, hcount 0 (896 T-states * 8 clocks)
    localparam int L4 = 7168;

    zx_cpu_sched #(.DISP_LINE(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .a      (a),
        .mreq   (mreq),
        .iorq   (iorq),
        .cep    (cep),
        .cen    (cen),
        .mi     (mi),
        .hcount (hcount),
        .vcount (vcount),
        .stall  (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        n = n + 1;
    endtask

    task automatic step_to(input int target);
        while (n < target) step();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cep"},    32'(cep),    32'd0);
        chk({tag, "_cen"},    32'(cen),    32'd0);
        chk({tag, "_mi"},     32'(mi),     32'd1);
        chk({tag, "_stall"},  32'(stall),  32'd0);
        chk({tag, "_hcount"}, 32'(hcount), 32'd0);
        chk({tag, "_vcount"}, 32'(vcount), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        n        = -1;
`ifdef ZX_CONTEND_IO_EN
        exp_io = 1;
`else
        exp_io = 0;
`endif
        reset = 1'b0;
        a     = 16'h0000;
        mreq  = 1'b1;
        iorq  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("rst");
        @(negedge clock);
        reset = 1'b1;

        // Idle cadence: cep at phase 0, cen four clocks later, no stall
        for (int e = 0; e < 32; e++) begin
            step();
            chk("cep_cadence", 32'(cep),    32'((e % 8) == 0));
            chk("cen_cadence", 32'(cen),    32'((e % 8) == 4));
            chk("hcount_inc",  32'(hcount), 32'((e + 1) / 8));
        end
        chk("idle_stall", 32'(stall), 32'd0);

        // Interrupt low for 32 T-states from frame T-state 0
        step_to(255);
        chk("mi_low_end", 32'(mi), 32'd0);
        step_to(256);
        chk("mi_rise", 32'(mi), 32'd1);

        // Line wrap
        step_to(1790);
        chk("vcount_pre_wrap", 32'(vcount), 32'd0);
        step_to(1791);
        chk("vcount_wrap", 32'(vcount), 32'd1);
        chk("hcount_wrap", 32'(hcount), 32'd0);

        // Contended address on line 1, outside the line window
        a    = 16'h4000;
        mreq = 1'b0;
        step_to(1792);
        chk("line1_stall", 32'(stall), 32'd0);
        chk("line1_cep",   32'(cep),   32'd1);
        mreq = 1'b1;

        // Line 4, hcount 0: six T-state stall
        step_to(L4 - 1);
        mreq = 1'b0;
        step_to(L4);
        chk("c0_stall", 32'(stall), 32'd1);
        chk("c0_cep",   32'(cep),   32'd0);
        step_to(L4 + 40);
        chk("c0_cep_sup", 32'(cep), 32'd0);
        step_to(L4 + 44);
        chk("c0_cen_sup", 32'(cen), 32'd0);
        step_to(L4 + 47);
        chk("c0_stall_hold", 32'(stall), 32'd1);
        step_to(L4 + 48);
        chk("c0_release",   32'(stall),  32'd0);
        chk("c0_cep_back",  32'(cep),    32'd1);
        chk("c0_hcount",    32'(hcount), 32'd6);
        step_to(L4 + 52);
        chk("c0_cen_back", 32'(cen), 32'd1);
        // Same access still active: held prevents re-stall
        step_to(L4 + 56);
        chk("held_no_stall", 32'(stall), 32'd0);
        chk("held_cep",      32'(cep),   32'd1);
        step_to(L4 + 57);
        mreq = 1'b1;

        // hcount 14 (index 6): table value 0, no stall
        step_to(L4 + 111);
        mreq = 1'b0;
        step_to(L4 + 112);
        chk("idx6_stall", 32'(stall), 32'd0);
        chk("idx6_cep",   32'(cep),   32'd1);
        step_to(L4 + 113);
        mreq = 1'b1;

        // Uncontended address at hcount 16
        step_to(L4 + 127);
        a    = 16'h8000;
        mreq = 1'b0;
        step_to(L4 + 128);
        chk("a8000_stall", 32'(stall), 32'd0);
        step_to(L4 + 129);
        mreq = 1'b1;

        // hcount 128: just past the T-state window
        step_to(L4 + 1023);
        a    = 16'h4000;
        mreq = 1'b0;
        step_to(L4 + 1024);
        chk("h128_stall", 32'(stall), 32'd0);
        chk("h128_cep",   32'(cep),   32'd1);
        step_to(L4 + 1025);
        mreq = 1'b1;

        // Line 5, hcount 122 (index 2): four T-state stall
        step_to(9935);
        mreq = 1'b0;
        step_to(9936);
        chk("c2_stall", 32'(stall), 32'd1);
        step_to(9967);
        chk("c2_stall_hold", 32'(stall), 32'd1);
        step_to(9968);
        chk("c2_release",  32'(stall),  32'd0);
        chk("c2_cep_back", 32'(cep),    32'd1);
        chk("c2_hcount",   32'(hcount), 32'd126);
        step_to(9969);
        mreq = 1'b1;

        // Line 6, hcount 3: I/O port 0xFE, three T-states only when I/O contention is built in
        step_to(10775);
        a    = 16'h00FE;
        iorq = 1'b0;
        step_to(10776);
        chk("io_stall", 32'(stall), 32'(exp_io));
        chk("io_cep",   32'(cep),   32'(1 - exp_io));
        step_to(10799);
        chk("io_stall_hold", 32'(stall), 32'(exp_io));
        step_to(10800);
        chk("io_release", 32'(stall), 32'd0);
        chk("io_cep_end", 32'(cep),   32'd1);
        step_to(10801);
        iorq = 1'b1;

        // Line 7, hcount 2: stall interrupted by reset
        step_to(12559);
        a    = 16'h4000;
        mreq = 1'b0;
        step_to(12560);
        chk("rs_stall", 32'(stall), 32'd1);
        step_to(12570);
        #1;
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        mreq = 1'b1;
        repeat (3) step();
        chk("rst_hold_cep", 32'(cep), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        n = -1;
        step_to(0);
        chk("rel_cep0",   32'(cep),   32'd1);
        chk("rel_stall",  32'(stall), 32'd0);
        step_to(4);
        chk("rel_cen4",   32'(cen),   32'd1);
        chk("rel_cep4",   32'(cep),   32'd0);
        step_to(8);
        chk("rel_cep8",   32'(cep),   32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/zx_cpu_sched.md
Name: zx_cpu_sched

Overview:
- Clock-enable scheduler and interrupt source for the Z80 core in the 48K machine.
- Divides the master clock into T-states and emits the cep/cen enable pulses the CPU consumes.
- Stretches CPU cycles with ULA-style memory contention during the display fetch window.
- Tracks the frame position and drives the active-low maskable interrupt (mi) once per frame.

Parameters:
- DIV, 8, master clocks per T-state; even, >=4.
- LINE_T, 224, T-states per scan line.
- LINES, 312, lines per frame.
- DISP_LINE, 64, first contended line; the window is DISP_LINE..DISP_LINE+191.
- CONT_START, 0, first contended T-state in a line; the window is CONT_START..CONT_START+127.
- INT_START, 0, frame T-state at which mi falls.
- INT_LEN, 32, mi low duration in T-states.

Ports:
- clock  in  1  master clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- a  in  16  CPU address bus.
- mreq  in  1  CPU MREQ, active low.
- iorq  in  1  CPU IORQ, active low.
- cep  out  1  CPU positive-phase clock enable; one-clock pulse.
- cen  out  1  CPU negative-phase clock enable; one-clock pulse.
- mi  out  1  CPU INT, active low.
- hcount  out  8  T-state within the line, 0..LINE_T-1.
- vcount  out  9  line within the frame, 0..LINES-1.
- stall  out  1  high while the CPU is held by contention.

Behaviour:
- Clock and reset: single clock domain. The reset polarity and synchronicity are fixed as stated: asynchronous, active-low.
- Reset values: cep=0, cen=0, mi=1, stall=0, hcount=0, vcount=0, phase=0, delay=0, held=0. The first cep occurs at phase 0 after reset release.
- Phase counter: counts 0..DIV-1 free-running, independent of contention.
  - At phase DIV-1, hcount increments, wrapping at LINE_T.
  - On an hcount wrap, vcount increments, wrapping at LINES.
- Enable pulses: all outputs are registered.
  - cep is high for exactly one clock at phase 0 when not stalled.
  - cen is high for exactly one clock at phase DIV/2 when not stalled.
  - Nominal period is DIV clocks; cen lags cep by DIV/2 clocks.
- Contended predicate (evaluated at phase 0):
  - mreq=0 and a[15:14]=2'b01, and
  - vcount is in the line window, and
  - hcount is in the T-state window, and
  - held=0.
- Delay table, indexed by (hcount-CONT_START)[2:0]: 0->6, 1->5, 2->4, 3->3, 4->2, 5->1, 6->0, 7->0.
- Contention state machine (states RUN / STALL):
  - RUN: at phase 0, if the predicate is true and the table value is nonzero, load delay, set stall=1 and go to STALL, suppressing this cep and the following cen.
  - RUN: if the predicate is true and the table value is 0, set held=1 and issue cep normally.
  - STALL: at each phase 0, decrement delay; cep/cen stay suppressed.
  - STALL: when delay reaches 0 at phase 0, clear stall, set held=1, issue cep that clock, return to RUN.
  - held clears when mreq=1 and iorq=1 are sampled at phase 0. This prevents re-stalling the same access.
- Interrupt: mi is updated at phase 0. It is 0 while the frame T-state (vcount*LINE_T+hcount) is in [INT_START, INT_START+INT_LEN), otherwise 1.
  - mi is independent of stall; the frame counters never stop.
- Boundaries:
  - A stall crossing the line or frame wrap continues normally; the counters wrap independently.
  - A contended request arriving at the last window T-state uses the table value for that index; the stall may extend past the window.
  - Reset asserted mid-stall returns immediately to reset values; no pending cep is emitted.
- Widths: hcount and vcount must hold LINE_T-1 and LINES-1; the frame T-state comparison uses 17 bits.

Optional Feature:
- Macro: ZX_CONTEND_IO_EN.
- Defined: the predicate also fires for iorq=0 with a[0]=0, or iorq=0 with a[15:14]=2'b01. The same delay table and state machine apply.
- Undefined: I/O cycles are never contended; only mreq accesses are considered.

Test Plan:
- Reset release, no requests -> cep every 8 clocks, first at phase 0; cen 4 clocks after each cep; stall=0.
- Free run for one frame -> mi=0 for exactly 256 clocks (32 T-states) starting at frame T-state 0; mi repeats every 69888 T-states (559104 clocks).
- mreq=0, a=16'h4000 at vcount=64, hcount=0 -> stall=1; no cep for 6 T-states (48 clocks); cep resumes at hcount=6; held=1 until mreq=1 and iorq=1.
- Same access at hcount=6 -> no stall; same access at vcount=10 or a=16'h8000 -> no stall.
- Contended access at vcount=64, hcount=2, reset pulled low 10 clocks later -> all outputs return to reset values immediately; cep restarts 8-clock cadence after release.
- With ZX_CONTEND_IO_EN, iorq=0, a=16'h00FE at vcount=100, hcount=3 -> 3 T-state stall. Without the macro, the same stimulus produces no stall.
